// File: rtl/rv_g_wb_arbiter_if.sv
// Writeback arbiter bus: per-source result beats in, register-file write/unlock port out.
// The slave modport is the arbiter's view; the master modport is the execution-unit /
// register-file side that drives results and observes the write port.
interface rv_g_wb_arbiter_if #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned XLEN    = 64,
    parameter int unsigned FLEN    = 32
);
    localparam int unsigned MaxLen = (FLEN > XLEN) ? FLEN : XLEN;

    // Per-source result beats
    logic [NUM_SRC-1:0]             src_valid_i;
    logic [NUM_SRC-1:0][5:0]        src_addr_i;
    logic [NUM_SRC-1:0][MaxLen-1:0] src_data_i;
    logic [NUM_SRC-1:0]             src_ready_o;

    // Register-file write/unlock port
    logic [5:0]                     wr_addr_o;
    logic [MaxLen-1:0]              wr_data_o;
    logic                           wr_en_o;

    modport master (
        output src_valid_i,
        output src_addr_i,
        output src_data_i,
        input  src_ready_o,
        input  wr_addr_o,
        input  wr_data_o,
        input  wr_en_o
    );

    modport slave (
        input  src_valid_i,
        input  src_addr_i,
        input  src_data_i,
        output src_ready_o,
        output wr_addr_o,
        output wr_data_o,
        output wr_en_o
    );
endinterface

// File: rtl/rv_g_wb_arbiter.sv
// Writeback-stage round-robin arbiter.
// Merges result beats from NUM_SRC execution units onto the single register-file write/unlock
// port. At most one beat is accepted per cycle; the winner is registered onto wr_*_o with a
// latency of one cycle, so a sustained throughput of one write per cycle is possible.
// rr_q names the highest-priority source; after a grant it moves to the source after the winner,
// which bounds the wait of a continuously valid source to NUM_SRC cycles.
// Optional build macro RV_G_WB_DROP_X0_EN: beats addressed to integer x0 (6'd0) are accepted but
// produce no register-file write (x0 is never locked, so no unlock is needed either).
module rv_g_wb_arbiter #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned XLEN    = 64,
    parameter int unsigned FLEN    = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    rv_g_wb_arbiter_if.slave  bus
);

    localparam int unsigned MaxLen = (FLEN > XLEN) ? FLEN : XLEN;
    localparam int unsigned RrW    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    // Round-robin pointer
    logic [RrW-1:0]    rr_q, rr_d;

    // Output register
    logic              wr_en_q, wr_en_d;
    logic [5:0]        wr_addr_q, wr_addr_d;
    logic [MaxLen-1:0] wr_data_q, wr_data_d;

    // Arbitration results
    logic              grant_any;
    logic [RrW-1:0]    grant_idx;
    logic [RrW-1:0]    cand_idx;
    logic [NUM_SRC-1:0] ready;
    logic              drop_x0;

    // Source index reached after stepping off positions from base, wrapping at NUM_SRC.
    // base is always below NUM_SRC after reset, so one subtraction is enough.
    function automatic logic [RrW-1:0] scan_idx(input logic [RrW-1:0] base,
                                                input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NUM_SRC) begin
            sum = sum - NUM_SRC;
        end
        return sum[RrW-1:0];
    endfunction

    // Scan from rr_q upwards (mod NUM_SRC) and grant the first valid source; none in reset.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand_idx  = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            cand_idx = scan_idx(rr_q, i);
            if (!grant_any && bus.src_valid_i[cand_idx]) begin
                grant_any = 1'b1;
                grant_idx = cand_idx;
            end
        end
        if (rst_i) begin
            grant_any = 1'b0;
        end
    end

    // One-hot accept towards the granted source.
    always_comb begin
        ready = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            ready[k] = grant_any && (grant_idx == RrW'(k));
        end
    end

`ifdef RV_G_WB_DROP_X0_EN
    // Integer x0 only; FP f0 (6'd32) is a real write.
    assign drop_x0 = (bus.src_addr_i[grant_idx] == 6'd0);
`else
    assign drop_x0 = 1'b0;
`endif

    // Next pointer and next write-port contents; address/data hold when nothing is written.
    always_comb begin
        rr_d      = rr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (grant_any) begin
            rr_d = (grant_idx == RrW'(NUM_SRC - 1)) ? '0 : grant_idx + RrW'(1);
            if (!drop_x0) begin
                wr_en_d   = 1'b1;
                wr_addr_d = bus.src_addr_i[grant_idx];
                wr_data_d = bus.src_data_i[grant_idx];
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q      <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            rr_q      <= rr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.src_ready_o = ready;
    assign bus.wr_en_o     = wr_en_q;
    assign bus.wr_addr_o   = wr_addr_q;
    assign bus.wr_data_o   = wr_data_q;

    // Protocol invariants
    a_ready_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(bus.src_ready_o));
    a_ready_needs_valid : assert property (@(posedge clk_i) disable iff (rst_i)
        (bus.src_ready_o & ~bus.src_valid_i) == '0);
    a_no_ready_in_reset : assert property (@(posedge clk_i)
        rst_i |-> (bus.src_ready_o == '0));
    a_rr_in_range : assert property (@(posedge clk_i) disable iff (rst_i)
        32'(rr_q) < NUM_SRC);
    a_write_follows_grant : assert property (@(posedge clk_i) disable iff (rst_i)
        (grant_any && !drop_x0) |=> wr_en_q);

endmodule

// File: tb/tb_rv_g_wb_arbiter.sv
// Directed bench for rv_g_wb_arbiter (NUM_SRC=4, XLEN=64, FLEN=32).
// The stimulus process drives one cycle at a time and queues the hand-computed expectations:
// the accept pattern for the current cycle and the write-port contents for the next cycle.
// A monitor on the falling edge pops and compares whatever is due that cycle.
module tb_rv_g_wb_arbiter;

    localparam int unsigned NSrc = 4;
    localparam int unsigned XLen = 64;
    localparam int unsigned FLen = 32;

    localparam logic [63:0] DA = 64'hAAAA_0000_0000_00A0;
    localparam logic [63:0] DB = 64'hBBBB_0000_0000_00B1;
    localparam logic [63:0] DC = 64'hCCCC_0000_0000_00C2;
    localparam logic [63:0] DD = 64'hDDDD_0000_0000_00D3;

    typedef struct {
        int unsigned cyc;
        logic [3:0]  rdy;
    } rdy_exp_t;

    typedef struct {
        int unsigned cyc;
        logic        en;
        logic [5:0]  addr;
        logic [63:0] data;
    } out_exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rv_g_wb_arbiter_if #(.NUM_SRC(NSrc), .XLEN(XLen), .FLEN(FLen)) bus ();

    rv_g_wb_arbiter #(.NUM_SRC(NSrc), .XLEN(XLen), .FLEN(FLen)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    rdy_exp_t    rdy_q[$];
    out_exp_t    out_q[$];
    rdy_exp_t    re;
    out_exp_t    oe;
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    bit          end_req = 1'b0;
    bit          end_ack = 1'b0;
    logic [5:0]  hold_a = '0;
    logic [63:0] hold_d = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    // Monitor: compare everything due in the current cycle.
    always @(negedge clk) begin
        if (rdy_q.size() > 0 && rdy_q[0].cyc == cyc) begin
            re = rdy_q.pop_front();
            chk("src_ready", 64'(bus.src_ready_o), 64'(re.rdy));
        end
        if (out_q.size() > 0 && out_q[0].cyc == cyc) begin
            oe = out_q.pop_front();
            chk("wr_en", 64'(bus.wr_en_o), 64'(oe.en));
            chk("wr_addr", 64'(bus.wr_addr_o), 64'(oe.addr));
            chk("wr_data", bus.wr_data_o, oe.data);
        end else if (bus.wr_en_o !== 1'b0) begin
            chk("unexpected_wr_en", 64'(bus.wr_en_o), 64'd0);
        end
        if (end_req && !end_ack) begin
            chk("queues_drained", 64'(rdy_q.size() + out_q.size()), 64'd0);
            end_ack = 1'b1;
        end
    end

    task automatic src(input int k, input logic [5:0] a, input logic [63:0] d);
        bus.src_addr_i[k] = a;
        bus.src_data_i[k] = d;
    endtask

    // Drive one cycle: r=reset, v=valids, rdy=expected accept, wr/ea/ed=expected write next cycle.
    task automatic step(input logic r, input logic [3:0] v, input logic [3:0] rdy,
                        input logic wr, input logic [5:0] ea, input logic [63:0] ed);
        rdy_exp_t rx;
        out_exp_t ox;
        rst = r;
        bus.src_valid_i = v;
        rx.cyc = cyc;
        rx.rdy = rdy;
        rdy_q.push_back(rx);
        ox.cyc = cyc + 1;
        if (r) begin
            hold_a = '0;
            hold_d = '0;
            ox.en = 1'b0;
        end else if (wr) begin
            hold_a = ea;
            hold_d = ed;
            ox.en = 1'b1;
        end else begin
            ox.en = 1'b0;
        end
        ox.addr = hold_a;
        ox.data = hold_d;
        out_q.push_back(ox);
        @(posedge clk);
        #1;
    endtask

    task automatic std_srcs();
        src(0, 6'd1, DA);
        src(1, 6'd2, DB);
        src(2, 6'd3, DC);
        src(3, 6'd33, DD);
    endtask

    initial begin
        rst = 1'b1;
        bus.src_valid_i = '0;
        bus.src_addr_i = '0;
        bus.src_data_i = '0;
        @(posedge clk);
        #1;
        std_srcs();

        // Reset held with every source valid
        step(1'b1, 4'hF, 4'b0000, 1'b0, 6'd0, 64'd0);
        step(1'b1, 4'hF, 4'b0000, 1'b0, 6'd0, 64'd0);

        // Round-robin with all sources valid
        step(1'b0, 4'hF, 4'b0001, 1'b1, 6'd1, DA);
        step(1'b0, 4'hF, 4'b0010, 1'b1, 6'd2, DB);
        step(1'b0, 4'hF, 4'b0100, 1'b1, 6'd3, DC);
        step(1'b0, 4'hF, 4'b1000, 1'b1, 6'd33, DD);
        step(1'b0, 4'hF, 4'b0001, 1'b1, 6'd1, DA);
        step(1'b0, 4'h0, 4'b0000, 1'b0, 6'd0, 64'd0);

        // Sparse: src2 alone, then all valid shows the pointer moved to 3
        src(2, 6'd5, 64'hDEAD);
        step(1'b0, 4'b0100, 4'b0100, 1'b1, 6'd5, 64'hDEAD);
        step(1'b0, 4'h0, 4'b0000, 1'b0, 6'd0, 64'd0);
        src(2, 6'd3, DC);
        step(1'b0, 4'hF, 4'b1000, 1'b1, 6'd33, DD);

        // Hold/stall: src1 waits one cycle behind src0 with stable data
        src(1, 6'd6, 64'h1111_2222_3333_4444);
        step(1'b0, 4'b0011, 4'b0001, 1'b1, 6'd1, DA);
        step(1'b0, 4'b0010, 4'b0010, 1'b1, 6'd6, 64'h1111_2222_3333_4444);

        // Bring the pointer back to 0, then same-destination pair serialized in scan order
        src(3, 6'd9, 64'h99);
        step(1'b0, 4'b1000, 4'b1000, 1'b1, 6'd9, 64'h99);
        src(0, 6'd7, 64'h11);
        src(3, 6'd7, 64'h33);
        step(1'b0, 4'b1001, 4'b0001, 1'b1, 6'd7, 64'h11);
        step(1'b0, 4'b1000, 4'b1000, 1'b1, 6'd7, 64'h33);
        step(1'b0, 4'h0, 4'b0000, 1'b0, 6'd0, 64'd0);

        // Integer x0 from src1
        src(1, 6'd0, 64'hFF);
`ifdef RV_G_WB_DROP_X0_EN
        step(1'b0, 4'b0010, 4'b0010, 1'b0, 6'd0, 64'd0);
`else
        step(1'b0, 4'b0010, 4'b0010, 1'b1, 6'd0, 64'hFF);
`endif
        step(1'b0, 4'h0, 4'b0000, 1'b0, 6'd0, 64'd0);
        // Pointer is 2 either way; FP f0 (32) is always written
        std_srcs();
        src(3, 6'd32, 64'h3232);
        step(1'b0, 4'hF, 4'b0100, 1'b1, 6'd3, DC);
        step(1'b0, 4'hF, 4'b1000, 1'b1, 6'd32, 64'h3232);

        // Reset mid-stream: nothing accepted, write port cleared, pointer back to 0
        step(1'b1, 4'hF, 4'b0000, 1'b0, 6'd0, 64'd0);
        step(1'b0, 4'hF, 4'b0001, 1'b1, 6'd1, DA);
        step(1'b0, 4'h0, 4'b0000, 1'b0, 6'd0, 64'd0);
        step(1'b0, 4'h0, 4'b0000, 1'b0, 6'd0, 64'd0);

        end_req = 1'b1;
        for (int i = 0; i < 4 && !end_ack; i++) begin
            @(posedge clk);
        end
        if (!end_ack) begin
            $display("FAIL monitor_end_ack got=0 exp=1");
            $fatal(1, "monitor did not acknowledge end of run");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv_g_wb_arbiter.md
Name: rv_g_wb_arbiter

Overview:
- Writeback-stage arbiter that merges results from several execution units onto the single write/unlock port of the integer+FP register file.
- Each cycle it selects at most one valid result by round-robin and registers it onto wr_addr_o/wr_data_o/wr_en_o.
- These outputs drive the register file's wr_addr_i/wr_data_i/wr_en_i directly, which also clears the destination's lock.

Parameters:
- NUM_SRC, 4, number of result sources (legal 1..8).
- XLEN, 64, integer register width.
- FLEN, 32, floating-point register width.
- MaxLen, localparam = max(FLEN, XLEN), write-data width.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- src_valid_i  in  NUM_SRC  per-source result valid.
- src_addr_i  in  NUM_SRC x 6  per-source destination; bit5=1 selects FP file, bits[4:0] select the register.
- src_data_i  in  NUM_SRC x MaxLen  per-source result data.
- src_ready_o  out  NUM_SRC  per-source accept, one-hot or zero.
- wr_addr_o  out  6  register-file write/unlock address.
- wr_data_o  out  MaxLen  register-file write data.
- wr_en_o  out  1  register-file write/unlock enable.

Behaviour:
- Reset is synchronous: when rst_i=1 at a rising edge, rr_q=0, wr_en_o=0, wr_addr_o=0, wr_data_o=0.
- While rst_i=1, src_ready_o=0 combinationally.
- Handshake:
  - A beat transfers on src_valid_i[k] & src_ready_o[k].
  - A source holds valid, addr and data stable until its beat transfers.
  - Ready may depend combinationally on valid; valid must not depend on ready.
- Arbitration (combinational):
  - rr_q (clog2(NUM_SRC) bits, min 1) names the highest-priority source.
  - Scan sources rr_q, rr_q+1, ... modulo NUM_SRC.
  - The first source with valid=1 is granted, g.
  - src_ready_o = onehot(g) if any valid, else 0.
  - Exactly one beat is accepted per cycle maximum.
- Pointer update:
  - On a grant, rr_q <= (g+1) mod NUM_SRC.
  - With no grant, rr_q holds.
  - For NUM_SRC=1, rr_q stays 0 and src_ready_o[0]=src_valid_i[0].
- Output register:
  - On a grant: wr_en_o<=1, wr_addr_o<=src_addr_i[g], wr_data_o<=src_data_i[g].
  - Otherwise: wr_en_o<=0, and wr_addr_o/wr_data_o hold their last value.
  - Latency from accepted beat to wr_en_o is exactly 1 cycle.
  - wr_en_o is high for exactly one cycle per accepted beat.
- No backpressure from the register file; a sustained throughput of 1 write/cycle is required.
- Starvation bound: a continuously valid source is granted within NUM_SRC cycles.
- Same-destination ordering:
  - Two sources targeting the same address in one cycle are serialized in scan order.
  - The later write is the final value.
  - No other ordering is guaranteed across sources.
- Data is passed through unmodified. The register file truncates to XLEN/FLEN; no NaN-boxing is done here.
- Reset asserted mid-stream:
  - Any beat presented in the reset cycle is not accepted.
  - A pending wr_en_o is cleared at the next edge.
  - Upstream units are reset by the same rst_i.

Optional Feature:
- Macro: RV_G_WB_DROP_X0_EN.
- Defined:
  - A granted beat with src_addr_i=6'd0 (integer x0) is accepted: ready=1 and rr_q advances.
  - wr_en_o<=0 that cycle, and wr_addr_o/wr_data_o hold.
  - This saves a write slot; x0 is never locked, so nothing needs unlocking.
  - FP address 6'd32 is not dropped.
- Undefined: x0 beats are forwarded like any other, with wr_en_o=1 and wr_addr_o=0.

Test Plan:
- Reset: rst_i=1 for 2 cycles with all src_valid_i=1 -> src_ready_o=0, wr_en_o=0, wr_addr_o=0, wr_data_o=0 throughout; first grant after release goes to source 0.
- Round-robin: NUM_SRC=4, all valid continuously, addresses 1,2,3,33 -> grants 0,1,2,3,0,...; wr_addr_o sequence 1,2,3,33,1 each one cycle after its grant; wr_en_o constantly 1.
- Sparse: only src2 valid with addr=5, data=0xDEAD for one beat -> src_ready_o=4'b0100 that cycle; next cycle wr_en_o=1, wr_addr_o=5, wr_data_o=0xDEAD; following cycle wr_en_o=0, rr_q=3.
- Hold/stall: src1 valid while src0 is granted -> src1 holds its data; it is granted the next cycle and its wr_data_o equals its held data.
- Same destination: src0 (data=0x11) and src3 (data=0x33) both addr=7, rr_q=0 -> wr_data_o=0x11 then 0x33 on consecutive cycles.
- x0 handling: src1 addr=0, data=0xFF accepted -> with RV_G_WB_DROP_X0_EN, wr_en_o=0 the next cycle and rr_q=2; without the macro, wr_en_o=1, wr_addr_o=0, wr_data_o=0xFF.
